// File: rtl/mdu_param_unit_pkg.sv
// ---------------------------------------------------------------------------
// mdu_param_unit_pkg
// Shared definitions for the multiply/divide unit: MDU opcodes (the same
// encoding the decoder emits), FSM state codes and small opcode classifiers.
// No ports; imported by mdu_param_unit and mdu_div_iter.
// ---------------------------------------------------------------------------
package mdu_param_unit_pkg;

    // MDU opcodes
    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MADD  = 4'd4;
    localparam logic [3:0] MDU_MADDU = 4'd5;
    localparam logic [3:0] MDU_MSUB  = 4'd6;
    localparam logic [3:0] MDU_MSUBU = 4'd7;
    localparam logic [3:0] MDU_MTHI  = 4'd8;
    localparam logic [3:0] MDU_MTLO  = 4'd9;

    // FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    // Multiply-class ops: mult/multu/madd/maddu/msub/msubu
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

    // Divide-class ops: div/divu
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Ops whose operands are treated as two's complement in the multiplier
    function automatic logic is_signed_mul(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// ---------------------------------------------------------------------------
// mdu_div_iter
// Restoring radix-2 divider working on magnitudes, one quotient bit per step.
// Signs requested at load are applied to the outputs, so after WIDTH steps
// quotient/remainder are the final signed results.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   load           capture magnitudes and sign flags, clear partial remainder
//   step           perform one restoring iteration
//   dividend_mag   |dividend|
//   divisor_mag    |divisor|
//   neg_q, neg_r   negate quotient / remainder on output
//   quotient       sign-fixed quotient
//   remainder      sign-fixed remainder
// ---------------------------------------------------------------------------
module mdu_div_iter
    import mdu_param_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend_mag,
    input  logic [WIDTH-1:0] divisor_mag,
    input  logic             neg_q,
    input  logic             neg_r,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH:0]   trial;

    // The dividend is shifted out of the quotient register MSB first while
    // quotient bits enter at the bottom. Since the partial remainder is always
    // below the divisor, the top bit of the (WIDTH+1)-bit difference is a
    // clean borrow flag.
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (load) begin
            rem_q   <= '0;
            quo_q   <= dividend_mag;
            dsr_q   <= divisor_mag;
            neg_q_q <= neg_q;
            neg_r_q <= neg_r;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                rem_q <= trial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = neg_q_q ? (~quo_q + 1'b1) : quo_q;
    assign remainder = neg_r_q ? (~rem_q + 1'b1) : rem_q;

endmodule

// File: rtl/mdu_param_unit.sv
// ---------------------------------------------------------------------------
// mdu_param_unit
// Parametrised multiply/divide unit with HI/LO for the E stage. Multiply-class
// ops stay busy MULT_LAT cycles, div/divu WIDTH+1 cycles (WIDTH iterations plus
// a sign-fixup cycle). mthi/mtlo write in one cycle. req aborts and blocks.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   req          flush: abort in-flight op, block new ops and mthi/mtlo
//   op_valid     op carries a real MDU instruction
//   op           MDU opcode
//   in1, in2     rs / rt operands
//   start        op accepted this cycle (combinational)
//   busy         operation in flight
//   hi, lo       HI / LO registers
// ---------------------------------------------------------------------------
module mdu_param_unit
    import mdu_param_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DIV_LAT = WIDTH + 1;
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] DIV_STEPS = CNT_W'(WIDTH);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               dz_q;

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mul_result;

    logic               div_signed;
    logic [WIDTH-1:0]   dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;
    logic               div_step;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    assign busy  = (state != ST_IDLE);
    assign start = op_valid && (is_mul_op(op) || is_div_op(op)) && !busy && !req;

    // Sign- or zero-extending both operands to 2*WIDTH makes one unsigned
    // multiplier produce the correct signed product modulo 2^(2*WIDTH).
    always_comb begin
        a_ext = {{WIDTH{1'b0}}, a_q};
        b_ext = {{WIDTH{1'b0}}, b_q};
        if (is_signed_mul(op_q)) begin
            a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end
    end

    assign product = a_ext * b_ext;

    // Accumulating ops read {hi,lo} at the completion edge; it cannot change
    // while busy, so using the live registers is safe.
    always_comb begin
        mul_result = product;
        case (op_q)
            MDU_MADD, MDU_MADDU: mul_result = {hi, lo} + product;
            MDU_MSUB, MDU_MSUBU: mul_result = {hi, lo} - product;
            default:             mul_result = product;
        endcase
    end

    // Divider is fed magnitudes straight from the operand ports at accept.
    // Quotient is negative when signs differ; remainder follows the dividend.
    assign div_signed   = (op == MDU_DIV);
    assign dividend_mag = (div_signed && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
    assign divisor_mag  = (div_signed && in2[WIDTH-1]) ? (~in2 + 1'b1) : in2;
    assign div_step     = (state == ST_DIV) && (cnt <= DIV_STEPS);

    mdu_div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk          (clk),
        .reset        (reset),
        .load         (start && is_div_op(op)),
        .step         (div_step),
        .dividend_mag (dividend_mag),
        .divisor_mag  (divisor_mag),
        .neg_q        (div_signed && (in1[WIDTH-1] ^ in2[WIDTH-1])),
        .neg_r        (div_signed && in1[WIDTH-1]),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    // Control FSM. cnt numbers the busy cycles from 1; the op completes on
    // the edge that ends its last busy cycle. req beats completion, so an
    // aborted op never writes hi/lo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            dz_q  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= in1;
                        b_q   <= in2;
                        dz_q  <= (in2 == '0);
                        cnt   <= CNT_W'(1);
                        state <= is_div_op(op) ? ST_DIV : ST_MUL;
                    end else if (op_valid && !req) begin
                        if (op == MDU_MTHI) begin
                            hi <= in1;
                        end else if (op == MDU_MTLO) begin
                            lo <= in1;
                        end
                    end
                end
                ST_MUL: begin
                    if (req) begin
                        state <= ST_IDLE;
                    end else if (cnt == MUL_LAST) begin
                        {hi, lo} <= mul_result;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (req) begin
                        state <= ST_IDLE;
                    end else if (cnt == DIV_LAST) begin
                        if (dz_q) begin
                            hi <= a_q;
                            lo <= '1;
                        end else begin
                            hi <= remainder;
                            lo <= quotient;
                        end
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_param_unit.sv
// ---------------------------------------------------------------------------
// tb_mdu_param_unit
// Directed bench for mdu_param_unit: a WIDTH=32/MULT_LAT=5 instance (a) and a
// WIDTH=16/MULT_LAT=1 instance (b) sharing one clock.
// ---------------------------------------------------------------------------
module tb_mdu_param_unit;

    logic        clk = 1'b0;

    logic        reset_a, req_a, op_valid_a, start_a, busy_a;
    logic [3:0]  op_a;
    logic [31:0] in1_a, in2_a, hi_a, lo_a;

    logic        reset_b, req_b, op_valid_b, start_b, busy_b;
    logic [3:0]  op_b;
    logic [15:0] in1_b, in2_b, hi_b, lo_b;

    int checks = 0;
    int errors = 0;
    int cyc;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    always #5 clk = ~clk;

    mdu_param_unit #(.WIDTH(32), .MULT_LAT(5)) dut_a (
        .clk(clk), .reset(reset_a), .req(req_a), .op_valid(op_valid_a), .op(op_a),
        .in1(in1_a), .in2(in2_a), .start(start_a), .busy(busy_a), .hi(hi_a), .lo(lo_a)
    );

    mdu_param_unit #(.WIDTH(16), .MULT_LAT(1)) dut_b (
        .clk(clk), .reset(reset_b), .req(req_b), .op_valid(op_valid_b), .op(op_b),
        .in1(in1_b), .in2(in2_b), .start(start_b), .busy(busy_b), .hi(hi_b), .lo(lo_b)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one op for a cycle on the chosen instance, then count busy
    // cycles until it finishes (bounded)
    task automatic applyStimulus(input bit use_b, input logic [3:0] o,
                                 input logic [31:0] a, input logic [31:0] bv,
                                 output int cycles);
        if (!use_b) begin
            op_valid_a = 1'b1; op_a = o; in1_a = a; in2_a = bv;
        end else begin
            op_valid_b = 1'b1; op_b = o; in1_b = a[15:0]; in2_b = bv[15:0];
        end
        @(posedge clk); #1;
        op_valid_a = 1'b0;
        op_valid_b = 1'b0;
        cycles = 0;
        while (((!use_b && busy_a) || (use_b && busy_b)) && cycles < 200) begin
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_a = 1'b0; req_a = 1'b0; op_valid_a = 1'b0; op_a = '0; in1_a = '0; in2_a = '0;
        reset_b = 1'b0; req_b = 1'b0; op_valid_b = 1'b0; op_b = '0; in1_b = '0; in2_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'b0, busy_a}, 32'd0);
        checkOutput("rst_hi", hi_a, 32'd0);
        checkOutput("rst_lo", lo_a, 32'd0);
        reset_a = 1'b1;
        reset_b = 1'b1;
        @(posedge clk); #1;

        // multiply, signed and unsigned
        applyStimulus(0, OP_MULT, 32'hFFFF_FFFD, 32'd5, cyc);
        checkOutput("mult_cyc", cyc, 32'd5);
        checkOutput("mult_hi", hi_a, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo_a, 32'hFFFF_FFF1);
        applyStimulus(0, OP_MULTU, 32'hFFFF_FFFD, 32'd5, cyc);
        checkOutput("multu_hi", hi_a, 32'h0000_0004);
        checkOutput("multu_lo", lo_a, 32'hFFFF_FFF1);

        // divide
        applyStimulus(0, OP_DIVU, 32'd100, 32'd7, cyc);
        checkOutput("divu_cyc", cyc, 32'd33);
        checkOutput("divu_lo", lo_a, 32'd14);
        checkOutput("divu_hi", hi_a, 32'd2);
        applyStimulus(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        checkOutput("div_neg_lo", lo_a, 32'hFFFF_FFFD);
        checkOutput("div_neg_hi", hi_a, 32'hFFFF_FFFF);
        applyStimulus(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checkOutput("div_ovf_lo", lo_a, 32'h8000_0000);
        checkOutput("div_ovf_hi", hi_a, 32'd0);
        applyStimulus(0, OP_DIV, 32'd5, 32'd0, cyc);
        checkOutput("divz_cyc", cyc, 32'd33);
        checkOutput("divz_lo", lo_a, 32'hFFFF_FFFF);
        checkOutput("divz_hi", hi_a, 32'd5);

        // mthi/mtlo then accumulate
        op_valid_a = 1'b1; op_a = OP_MTHI; in1_a = 32'd1;
        #1;
        checkOutput("mthi_start", {31'b0, start_a}, 32'd0);
        @(posedge clk); #1;
        op_valid_a = 1'b0;
        checkOutput("mthi_hi", hi_a, 32'd1);
        applyStimulus(0, OP_MTLO, 32'd2, 32'd0, cyc);
        applyStimulus(0, OP_MADD, 32'd3, 32'd4, cyc);
        checkOutput("madd_hi", hi_a, 32'd1);
        checkOutput("madd_lo", lo_a, 32'h0000_000E);
        applyStimulus(0, OP_MTHI, 32'd0, 32'd0, cyc);
        applyStimulus(0, OP_MTLO, 32'd0, 32'd0, cyc);
        applyStimulus(0, OP_MSUBU, 32'd1, 32'd1, cyc);
        checkOutput("msubu_hi", hi_a, 32'hFFFF_FFFF);
        checkOutput("msubu_lo", lo_a, 32'hFFFF_FFFF);

        // mthi while busy is ignored
        op_valid_a = 1'b1; op_a = OP_MULT; in1_a = 32'd2; in2_a = 32'd3;
        @(posedge clk); #1;
        op_a = OP_MTHI; in1_a = 32'h0000_DEAD;
        checkOutput("busy_mthi_start", {31'b0, start_a}, 32'd0);
        @(posedge clk); #1;
        op_valid_a = 1'b0;
        cyc = 0;
        while (busy_a && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
        checkOutput("busy_mthi_hi", hi_a, 32'd0);
        checkOutput("busy_mthi_lo", lo_a, 32'd6);

        // req in busy cycle 3 aborts without writing
        op_valid_a = 1'b1; op_a = OP_MULT; in1_a = 32'd7; in2_a = 32'd7;
        @(posedge clk); #1;
        op_valid_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        checkOutput("req_busy", {31'b0, busy_a}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("req_hi", hi_a, 32'd0);
        checkOutput("req_lo", lo_a, 32'd6);
        op_valid_a = 1'b1; op_a = OP_MULT; in1_a = 32'd2; in2_a = 32'd2;
        #1;
        checkOutput("after_req_start", {31'b0, start_a}, 32'd1);
        #0;
        applyStimulus(0, OP_MULT, 32'd2, 32'd2, cyc);
        checkOutput("after_req_lo", lo_a, 32'd4);

        // req suppresses mtlo; unknown op is ignored
        op_valid_a = 1'b1; op_a = OP_MTLO; in1_a = 32'h55; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        op_a = 4'hF;
        #1;
        checkOutput("unk_start", {31'b0, start_a}, 32'd0);
        @(posedge clk); #1;
        op_valid_a = 1'b0;
        checkOutput("req_mtlo_lo", lo_a, 32'd4);
        checkOutput("unk_busy", {31'b0, busy_a}, 32'd0);

        // async reset in busy cycle 10 of a divide
        op_valid_a = 1'b1; op_a = OP_DIVU; in1_a = 32'd100; in2_a = 32'd3;
        @(posedge clk); #1;
        op_valid_a = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("mid_div_busy", {31'b0, busy_a}, 32'd1);
        #2;
        reset_a = 1'b0;
        #1;
        checkOutput("arst_busy", {31'b0, busy_a}, 32'd0);
        checkOutput("arst_hi", hi_a, 32'd0);
        checkOutput("arst_lo", lo_a, 32'd0);
        @(posedge clk); #1;
        reset_a = 1'b1;

        // WIDTH=16, MULT_LAT=1 regression
        applyStimulus(1, OP_MULT, 32'h0000_FFFD, 32'd5, cyc);
        checkOutput("b_mult_cyc", cyc, 32'd1);
        checkOutput("b_mult_hi", {16'b0, hi_b}, 32'h0000_FFFF);
        checkOutput("b_mult_lo", {16'b0, lo_b}, 32'h0000_FFF1);
        applyStimulus(1, OP_DIVU, 32'd100, 32'd7, cyc);
        checkOutput("b_divu_cyc", cyc, 32'd17);
        checkOutput("b_divu_lo", {16'b0, lo_b}, 32'd14);
        checkOutput("b_divu_hi", {16'b0, hi_b}, 32'd2);
        applyStimulus(1, OP_DIV, 32'h0000_8000, 32'h0000_FFFF, cyc);
        checkOutput("b_ovf_lo", {16'b0, lo_b}, 32'h0000_8000);
        checkOutput("b_ovf_hi", {16'b0, hi_b}, 32'd0);
        applyStimulus(1, OP_MTLO, 32'h0000_1234, 32'd0, cyc);
        checkOutput("b_mtlo", {16'b0, lo_b}, 32'h0000_1234);
        op_valid_b = 1'b1; op_b = OP_DIVU; in1_b = 16'd100; in2_b = 16'd3;
        @(posedge clk); #1;
        op_valid_b = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset_b = 1'b0;
        #1;
        checkOutput("b_arst_busy", {31'b0, busy_b}, 32'd0);
        checkOutput("b_arst_lo", {16'b0, lo_b}, 32'd0);
        @(posedge clk); #1;
        reset_b = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
